decode_execute: RTL and testbench

Combined decode and execute block for the multi-cycle RV32I core. The core drives one instruction word and PC in, and gets register-file read indices back. It then supplies the operand values and receives the ALU/branch result, destination index and next PC. Each half runs its own start/done handshake, so the core sequencer can step fetch → decode → execute → write-back.

---
 rtl/decode_execute.sv | 237 +++++++++++++++++++++++
 tb/tb_decode_execute.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/decode_execute.sv
//------------------------------------------------------------------
// decode_execute: RV32I decode + execute, each with start/done
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module decode_execute (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dec_start,
  input  logic [31:0] pc,
  input  logic [31:0] instr_raw,
  output logic        dec_done,
  output logic [4:0]  rs1_num,
  output logic [4:0]  rs2_num,
  input  logic        ex_start,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        ex_done,
  output logic [4:0]  rd_num,
  output logic [31:0] rd_val,
  output logic [31:0] store_data,
  output logic        is_jump,
  output logic [31:0] jump_dest
);

  // Class 0 is illegal so the reset (all-zero) decode executes as illegal
  localparam logic [3:0] CLS_ILLEGAL = 4'd0;
  localparam logic [3:0] CLS_LUI     = 4'd1;
  localparam logic [3:0] CLS_AUIPC   = 4'd2;
  localparam logic [3:0] CLS_JAL     = 4'd3;
  localparam logic [3:0] CLS_JALR    = 4'd4;
  localparam logic [3:0] CLS_BRANCH  = 4'd5;
  localparam logic [3:0] CLS_LOAD    = 4'd6;
  localparam logic [3:0] CLS_STORE   = 4'd7;
  localparam logic [3:0] CLS_OPIMM   = 4'd8;
  localparam logic [3:0] CLS_OP      = 4'd9;

  logic [3:0]  w_cls;
  logic [31:0] w_imm;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;

  logic [3:0]  r_cls;
  logic [31:0] r_pc;
  logic [31:0] r_imm;
  logic [2:0]  r_f3;
  logic        r_f7b5;
  logic [4:0]  r_rd;

  always_comb begin
    w_cls = CLS_ILLEGAL;
    case (instr_raw[6:0])
      7'b0110111: w_cls = CLS_LUI;
      7'b0010111: w_cls = CLS_AUIPC;
      7'b1101111: w_cls = CLS_JAL;
      7'b1100111: w_cls = CLS_JALR;
      7'b1100011: w_cls = CLS_BRANCH;
      7'b0000011: w_cls = CLS_LOAD;
      7'b0100011: w_cls = CLS_STORE;
      7'b0010011: w_cls = CLS_OPIMM;
      7'b0110011: w_cls = CLS_OP;
      default:    w_cls = CLS_ILLEGAL;
    endcase
  end

  always_comb begin
    w_imm = 32'd0;
    w_rs1 = 5'd0;
    w_rs2 = 5'd0;
    case (w_cls)
      CLS_LUI, CLS_AUIPC:
        w_imm = {instr_raw[31:12], 12'd0};
      CLS_JAL:
        w_imm = {{11{instr_raw[31]}}, instr_raw[31], instr_raw[19:12],
                 instr_raw[20], instr_raw[30:21], 1'b0};
      CLS_JALR, CLS_LOAD, CLS_OPIMM: begin
        w_imm = {{20{instr_raw[31]}}, instr_raw[31:20]};
        w_rs1 = instr_raw[19:15];
      end
      CLS_BRANCH: begin
        w_imm = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7],
                 instr_raw[30:25], instr_raw[11:8], 1'b0};
        w_rs1 = instr_raw[19:15];
        w_rs2 = instr_raw[24:20];
      end
      CLS_STORE: begin
        w_imm = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
        w_rs1 = instr_raw[19:15];
        w_rs2 = instr_raw[24:20];
      end
      CLS_OP: begin
        w_rs1 = instr_raw[19:15];
        w_rs2 = instr_raw[24:20];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cls    <= CLS_ILLEGAL;
      r_pc     <= 32'd0;
      r_imm    <= 32'd0;
      r_f3     <= 3'd0;
      r_f7b5   <= 1'b0;
      r_rd     <= 5'd0;
      rs1_num  <= 5'd0;
      rs2_num  <= 5'd0;
      dec_done <= 1'b0;
    end else if (dec_start) begin
      r_cls    <= w_cls;
      r_pc     <= pc;
      r_imm    <= w_imm;
      r_f3     <= instr_raw[14:12];
      r_f7b5   <= instr_raw[30];
      r_rd     <= instr_raw[11:7];
      rs1_num  <= w_rs1;
      rs2_num  <= w_rs2;
      dec_done <= 1'b1;
    end
  end

  logic [31:0] w_b;
  logic [4:0]  w_sh;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_sra;
  logic        w_lt;
  logic        w_ltu;
  logic        w_is_op;
  logic [31:0] w_alu;
  logic        w_taken;
  logic [31:0] w_addr;
  logic [31:0] w_pc_imm;
  logic [31:0] w_pc4;

  assign w_is_op  = (r_cls == CLS_OP);
  assign w_b      = (w_is_op || r_cls == CLS_BRANCH) ? rs2_val : r_imm;
  assign w_sh     = w_b[4:0];
  assign w_sum    = rs1_val + w_b;
  assign w_diff   = rs1_val - w_b;
  // Kept in its own assign so the arithmetic shift stays in a signed context
  assign w_sra    = $signed(rs1_val) >>> w_sh;
  assign w_lt     = $signed(rs1_val) < $signed(w_b);
  assign w_ltu    = rs1_val < w_b;
  assign w_addr   = rs1_val + r_imm;
  assign w_pc_imm = r_pc + r_imm;
  assign w_pc4    = r_pc + 32'd4;

  always_comb begin
    w_alu = 32'd0;
    case (r_f3)
      3'b000: w_alu = (w_is_op && r_f7b5) ? w_diff : w_sum;
      3'b001: w_alu = rs1_val << w_sh;
      3'b010: w_alu = {31'd0, w_lt};
      3'b011: w_alu = {31'd0, w_ltu};
      3'b100: w_alu = rs1_val ^ w_b;
      3'b101: w_alu = (w_is_op ? r_f7b5 : r_imm[10]) ? w_sra : (rs1_val >> w_sh);
      3'b110: w_alu = rs1_val | w_b;
      3'b111: w_alu = rs1_val & w_b;
      default: w_alu = 32'd0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_f3)
      3'b000: w_taken = (rs1_val == rs2_val);
      3'b001: w_taken = (rs1_val != rs2_val);
      3'b100: w_taken = w_lt;
      3'b101: w_taken = !w_lt;
      3'b110: w_taken = w_ltu;
      3'b111: w_taken = !w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  logic [4:0]  w_rd_num;
  logic [31:0] w_rd_val;
  logic        w_jump;
  logic [31:0] w_dest;

  always_comb begin
    w_rd_num = r_rd;
    w_rd_val = 32'd0;
    w_jump   = 1'b0;
    w_dest   = w_pc4;
    case (r_cls)
      CLS_LUI:   w_rd_val = r_imm;
      CLS_AUIPC: w_rd_val = w_pc_imm;
      CLS_JAL: begin
        w_rd_val = w_pc4;
        w_jump   = 1'b1;
        w_dest   = w_pc_imm;
      end
      CLS_JALR: begin
        w_rd_val = w_pc4;
        w_jump   = 1'b1;
        w_dest   = {w_addr[31:1], 1'b0};
      end
      CLS_BRANCH: begin
        w_rd_num = 5'd0;
        w_jump   = w_taken;
        w_dest   = w_taken ? w_pc_imm : w_pc4;
      end
      CLS_LOAD: w_rd_val = w_addr;
      CLS_STORE: begin
        w_rd_num = 5'd0;
        w_rd_val = w_addr;
      end
      CLS_OPIMM, CLS_OP: w_rd_val = w_alu;
      default: w_rd_num = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_num     <= 5'd0;
      rd_val     <= 32'd0;
      store_data <= 32'd0;
      is_jump    <= 1'b0;
      jump_dest  <= 32'd0;
      ex_done    <= 1'b0;
    end else if (ex_start) begin
      rd_num     <= w_rd_num;
      rd_val     <= w_rd_val;
      store_data <= rs2_val;
      is_jump    <= w_jump;
      jump_dest  <= w_dest;
      ex_done    <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_execute.sv
//------------------------------------------------------------------
// tb_decode_execute: directed self-checking bench for decode_execute
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_decode_execute;

  logic        clk;
  logic        rstn;
  logic        dec_start;
  logic [31:0] pc;
  logic [31:0] instr_raw;
  logic        dec_done;
  logic [4:0]  rs1_num;
  logic [4:0]  rs2_num;
  logic        ex_start;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        ex_done;
  logic [4:0]  rd_num;
  logic [31:0] rd_val;
  logic [31:0] store_data;
  logic        is_jump;
  logic [31:0] jump_dest;

  int checks = 0;
  int errors = 0;

  decode_execute dut (
    .clk(clk), .rstn(rstn), .dec_start(dec_start), .pc(pc), .instr_raw(instr_raw),
    .dec_done(dec_done), .rs1_num(rs1_num), .rs2_num(rs2_num), .ex_start(ex_start),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .ex_done(ex_done), .rd_num(rd_num),
    .rd_val(rd_val), .store_data(store_data), .is_jump(is_jump), .jump_dest(jump_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, release and sample 1 time unit after the rising edge
  task automatic dec(input logic [31:0] a_pc, input logic [31:0] a_instr);
    @(negedge clk);
    dec_start = 1'b1; pc = a_pc; instr_raw = a_instr;
    @(posedge clk); #1;
    dec_start = 1'b0;
  endtask

  task automatic ex(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ex_start = 1'b1; rs1_val = a; rs2_val = b;
    @(posedge clk); #1;
    ex_start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; dec_start = 1'b0; ex_start = 1'b0;
    pc = 32'd0; instr_raw = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dec_done", {31'd0, dec_done}, 32'd0);
    chk("rst_ex_done", {31'd0, ex_done}, 32'd0);
    chk("rst_jump_dest", jump_dest, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Execute before any decode runs the all-zero (illegal) decode
    ex(32'h5, 32'h6);
    chk("pre_dec_ex_done", {31'd0, ex_done}, 32'd1);
    chk("pre_dec_rd_num", {27'd0, rd_num}, 32'd0);
    chk("pre_dec_dest", jump_dest, 32'h4);

    // add x3,x3,x2
    dec(32'h0, 32'h002181B3);
    chk("add_dec_done", {31'd0, dec_done}, 32'd1);
    chk("add_rs1", {27'd0, rs1_num}, 32'd3);
    chk("add_rs2", {27'd0, rs2_num}, 32'd2);
    ex(32'd1, 32'd2);
    chk("add_rd_num", {27'd0, rd_num}, 32'd3);
    chk("add_rd_val", rd_val, 32'd3);
    chk("add_jump", {31'd0, is_jump}, 32'd0);
    chk("add_dest", jump_dest, 32'h4);
    chk("add_store", store_data, 32'd2);
    // rs1_val changes without ex_start must not disturb the result
    @(negedge clk); rs1_val = 32'h100;
    @(posedge clk); #1;
    chk("add_hold", rd_val, 32'd3);
    ex(32'hFFFFFFFF, 32'd1);
    chk("add_wrap", rd_val, 32'd0);

    // add x5,x3,x2 decoded on the same edge as executing the previous add
    @(negedge clk);
    dec_start = 1'b1; ex_start = 1'b1; pc = 32'h0; instr_raw = 32'h002182B3;
    rs1_val = 32'd10; rs2_val = 32'd20;
    @(posedge clk); #1;
    dec_start = 1'b0; ex_start = 1'b0;
    chk("overlap_rd_num", {27'd0, rd_num}, 32'd3);
    chk("overlap_rd_val", rd_val, 32'd30);
    ex(32'd1, 32'd2);
    chk("add5_rd_num", {27'd0, rd_num}, 32'd5);

    // beq x1,x1,+8 at 0x10
    dec(32'h10, 32'h00108463);
    ex(32'd7, 32'd7);
    chk("beq_t_jump", {31'd0, is_jump}, 32'd1);
    chk("beq_t_dest", jump_dest, 32'h18);
    chk("beq_t_rd", {27'd0, rd_num}, 32'd0);
    ex(32'd7, 32'd6);
    chk("beq_nt_jump", {31'd0, is_jump}, 32'd0);
    chk("beq_nt_dest", jump_dest, 32'h14);

    // jal x1,-4 at 0x20
    dec(32'h20, 32'hFFDFF0EF);
    ex(32'd0, 32'd0);
    chk("jal_rd", {27'd0, rd_num}, 32'd1);
    chk("jal_val", rd_val, 32'h24);
    chk("jal_jump", {31'd0, is_jump}, 32'd1);
    chk("jal_dest", jump_dest, 32'h1C);

    // jalr x1,0(x5) at 0x40
    dec(32'h40, 32'h000280E7);
    chk("jalr_rs1", {27'd0, rs1_num}, 32'd5);
    ex(32'h101, 32'd0);
    chk("jalr_val", rd_val, 32'h44);
    chk("jalr_dest", jump_dest, 32'h100);

    // sub x4,x1,x2
    dec(32'h0, 32'h40208233);
    ex(32'd5, 32'd7);
    chk("sub_val", rd_val, 32'hFFFFFFFE);

    // srai x6,x1,4
    dec(32'h0, 32'h4040D313);
    chk("srai_rs2", {27'd0, rs2_num}, 32'd0);
    ex(32'h80000000, 32'd0);
    chk("srai_val", rd_val, 32'hF8000000);

    // sltu x7,x1,x2 then slt x7,x1,x2
    dec(32'h0, 32'h0020B3B3);
    ex(32'd1, 32'hFFFFFFFF);
    chk("sltu_val", rd_val, 32'd1);
    dec(32'h0, 32'h0020A3B3);
    ex(32'd1, 32'hFFFFFFFF);
    chk("slt_val", rd_val, 32'd0);

    // lui x8,0x12345
    dec(32'h0, 32'h12345437);
    ex(32'd0, 32'd0);
    chk("lui_val", rd_val, 32'h12345000);
    chk("lui_rd", {27'd0, rd_num}, 32'd8);

    // Unknown opcode at 0x50
    dec(32'h50, 32'h0000007F);
    chk("ill_rs1", {27'd0, rs1_num}, 32'd0);
    ex(32'd3, 32'd4);
    chk("ill_rd", {27'd0, rd_num}, 32'd0);
    chk("ill_val", rd_val, 32'd0);
    chk("ill_dest", jump_dest, 32'h54);
    chk("ill_done", {31'd0, ex_done}, 32'd1);

    // Reset wins over a simultaneous dec_start
    @(negedge clk);
    rstn = 1'b0; dec_start = 1'b1; pc = 32'h80; instr_raw = 32'h002181B3;
    @(posedge clk); #1;
    dec_start = 1'b0; rstn = 1'b1;
    chk("rst2_dec_done", {31'd0, dec_done}, 32'd0);
    chk("rst2_rs1", {27'd0, rs1_num}, 32'd0);
    chk("rst2_ex_done", {31'd0, ex_done}, 32'd0);
    chk("rst2_dest", jump_dest, 32'd0);
    chk("rst2_store", store_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
